// File: rtl/ew_sequence_gen_if.sv
// Request channel for ew_sequence_gen: valid/ready handshake with direction and event count.
//   req_valid : request present (master -> slave)
//   req_ready : slave can accept a request (slave -> master)
//   req_dir   : 0 = eastbound (E leads), 1 = westbound (W leads)
//   req_count : number of traversal events to emit
interface ew_sequence_gen_if #(
  parameter int unsigned CNT_W = 8
);

  logic             req_valid;
  logic             req_ready;
  logic             req_dir;
  logic [CNT_W-1:0] req_count;

  modport master (
    output req_valid,
    output req_dir,
    output req_count,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    input  req_count,
    output req_ready
  );

endinterface

// File: rtl/ew_sequence_gen.sv
// East/west sensor pulse sequence generator.
// Emits req_count traversal events. Each event drives the lead sensor, then both
// sensors, then the trail sensor, and finishes with an idle gap. Requests arrive
// over a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request channel (req_valid/req_ready/req_dir/req_count), slave side
//   abort : synchronous cancel of the current request (ignored in IDLE)
//   E, W  : east / west sensor lines (registered)
//   busy  : high whenever the generator is not IDLE (registered)
//   done  : one-cycle pulse after a request completes normally (registered)
module ew_sequence_gen #(
  parameter int unsigned LEAD_CYC    = 2,
  parameter int unsigned OVERLAP_CYC = 2,
  parameter int unsigned TRAIL_CYC   = 2,
  parameter int unsigned GAP_CYC     = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ew_sequence_gen_if.slave    bus,
  input  logic                abort,
  output logic                E,
  output logic                W,
  output logic                busy,
  output logic                done
);

  // Phase counter holds (length - 1) of the longest phase.
  localparam int unsigned MAX_AB  = (LEAD_CYC > OVERLAP_CYC) ? LEAD_CYC : OVERLAP_CYC;
  localparam int unsigned MAX_CD  = (TRAIL_CYC > GAP_CYC) ? TRAIL_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    BOTH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              done_d;
  logic              e_d, w_d;
  logic              ready_q;

  // Reload value for the phase counter on entry to a state.
  function automatic logic [PH_W-1:0] phase_len(input state_t s);
    logic [PH_W-1:0] len;
    len = '0;
    case (s)
      LEAD:    len = PH_W'(LEAD_CYC - 1);
      BOTH:    len = PH_W'(OVERLAP_CYC - 1);
      TRAIL:   len = PH_W'(TRAIL_CYC - 1);
      GAP:     len = PH_W'(GAP_CYC - 1);
      default: len = '0;
    endcase
    return len;
  endfunction

  // Next-state, counters and next output levels.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (bus.req_valid) begin
        dir_d = bus.req_dir;
        rem_d = bus.req_count;
        if (bus.req_count != '0) begin
          state_d = LEAD;
          phase_d = phase_len(LEAD);
        end else begin
          // Empty request completes immediately without leaving IDLE.
          done_d = 1'b1;
        end
      end
    end else if (abort) begin
      state_d = IDLE;
      phase_d = '0;
      rem_d   = '0;
    end else if (phase_q != '0) begin
      phase_d = phase_q - PH_W'(1);
    end else begin
      case (state_q)
        LEAD: begin
          state_d = BOTH;
          phase_d = phase_len(BOTH);
        end
        BOTH: begin
          state_d = TRAIL;
          phase_d = phase_len(TRAIL);
        end
        TRAIL: begin
          state_d = GAP;
          phase_d = phase_len(GAP);
        end
        GAP: begin
          // Remaining count only decrements while above one, so it never wraps.
          if (rem_q > CNT_W'(1)) begin
            rem_d   = rem_q - CNT_W'(1);
            state_d = LEAD;
            phase_d = phase_len(LEAD);
          end else begin
            rem_d   = '0;
            state_d = IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
        end
      endcase
    end

    // Sensor levels are decoded from the state being entered so they register with it.
    e_d = ((state_d == LEAD) && !dir_d) || (state_d == BOTH) || ((state_d == TRAIL) && dir_d);
    w_d = ((state_d == LEAD) && dir_d)  || (state_d == BOTH) || ((state_d == TRAIL) && !dir_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      E       <= 1'b0;
      W       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      E       <= e_d;
      W       <= w_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      ready_q <= (state_d == IDLE);
    end
  end

  assign bus.req_ready = ready_q;

endmodule
